// File: rtl/lcd_msg_ctrl.sv
// HD44780 message controller: power-on delay, controller init, then
// two-line 16x2 frame writes selected from a fixed message table with
// an optional hex/BCD ID field rendered on line 2 of message 1.
module lcd_msg_ctrl #(
  parameter int CLK_DIV  = 50,
  parameter int POR_WAIT = 750000,
  parameter int CLR_WAIT = 100000,
  parameter int N_DIGITS = 7,
  parameter int BLANK_LZ = 0
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  iMSG_VALID,
  input  logic [3:0]            iMSG_SEL,
  input  logic [4*N_DIGITS-1:0] iID,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic [7:0]            LCD_DATA,
  output logic                  LCD_RW,
  output logic                  LCD_EN,
  output logic                  LCD_RS
);

  localparam logic [31:0] LP_XFER_LAST = 32'(3*CLK_DIV - 1);
  localparam logic [31:0] LP_EN_ON     = 32'(CLK_DIV);
  localparam logic [31:0] LP_EN_OFF    = 32'(2*CLK_DIV);
  localparam logic [31:0] LP_POR_LAST  = 32'(POR_WAIT - 1);
  localparam logic [31:0] LP_CLR_LAST  = 32'(CLR_WAIT - 1);

  typedef enum logic [2:0] {
    POR   = 3'd0,
    INIT  = 3'd1,
    IDLE  = 3'd2,
    ADDR1 = 3'd3,
    LINE1 = 3'd4,
    ADDR2 = 3'd5,
    LINE2 = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [31:0]           r_cnt, w_cnt_nxt;
  logic [3:0]            r_idx, w_idx_nxt;
  logic                  r_clr, w_clr_nxt;

  logic [3:0]            r_sel;
  logic [4*N_DIGITS-1:0] r_id;
  logic                  r_pend;
  logic [3:0]            r_pend_sel;
  logic [4*N_DIGITS-1:0] r_pend_id;

  logic [7:0]            r_lcd_data;
  logic                  r_lcd_en;
  logic                  r_lcd_rs;

  logic                  w_xfer;
  logic                  w_xfer_end;
  logic                  w_en;
  logic [7:0]            w_byte;
  logic                  w_rs;
  logic                  w_busy;

  // ASCII for one hex nibble: 0-9 then A-F.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // Character for an ID column; columns outside the digit field are blank.
  function automatic logic [7:0] id_char(input logic [4*N_DIGITS-1:0] id,
                                         input int col);
    logic [7:0] ch;
    logic [3:0] nib;
    logic       lead;
    ch   = 8'h20;
    lead = 1'b1;
    for (int d = 0; d < N_DIGITS; d++) begin
      nib = id[4*(N_DIGITS-1-d) +: 4];
      if (nib != 4'd0) lead = 1'b0;
      if (col == 7 + d) begin
        // The last digit is always shown so an all-zero ID reads as "0".
        if ((BLANK_LZ != 0) && lead && (d != N_DIGITS - 1)) ch = 8'h20;
        else                                                 ch = hex_ascii(nib);
      end
    end
    return ch;
  endfunction

  // Character at a given line/column of the selected message.
  function automatic logic [7:0] line_char(input logic [3:0] sel,
                                           input logic       line2,
                                           input logic [3:0] col,
                                           input logic [4*N_DIGITS-1:0] id);
    logic [127:0] s;
    int           c;
    c = int'(col);
    case (sel)
      4'd0:    s = line2 ? "   ID to Park   " : "   Enter Your   ";
      4'd1:    s = line2 ? "   ID:          " : " ACCESS GRANTED ";
      4'd2:    s = line2 ? "   Try Again    " : " ACCESS DENIED  ";
      4'd3:    s = line2 ? "   ID to Exit   " : "   Enter Your   ";
      4'd4:    s = line2 ? "Mode            " : "Administrator   ";
      4'd15:   s = line2 ? "       OFF      " : "    Parking     ";
      default: s = line2 ? "                " : "        X       ";
    endcase
    if ((sel == 4'd1) && line2 && (c >= 7) && (c <= 6 + N_DIGITS))
      return id_char(id, c);
    return s[8*(15-c) +: 8];
  endfunction

  assign w_xfer_end = (r_cnt == LP_XFER_LAST);
  assign w_busy     = !((r_state == IDLE) && !r_pend);

  // Byte currently on the wire and the EN phase within the 3-phase transfer.
  always_comb begin
    w_xfer = 1'b0;
    w_byte = 8'h00;
    w_rs   = 1'b0;
    case (r_state)
      INIT: begin
        w_xfer = !r_clr;
        case (r_idx[1:0])
          2'd0:    w_byte = 8'h38;
          2'd1:    w_byte = 8'h0C;
          2'd2:    w_byte = 8'h01;
          default: w_byte = 8'h06;
        endcase
      end
      ADDR1: begin
        w_xfer = 1'b1;
        w_byte = 8'h80;
      end
      LINE1: begin
        w_xfer = 1'b1;
        w_rs   = 1'b1;
        w_byte = line_char(r_sel, 1'b0, r_idx, r_id);
      end
      ADDR2: begin
        w_xfer = 1'b1;
        w_byte = 8'hC0;
      end
      LINE2: begin
        w_xfer = 1'b1;
        w_rs   = 1'b1;
        w_byte = line_char(r_sel, 1'b1, r_idx, r_id);
      end
      default: ;
    endcase
    w_en = w_xfer && (r_cnt >= LP_EN_ON) && (r_cnt < LP_EN_OFF);
  end

  // Next-state sequencing: delays, command/byte indexing, frame flow.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_clr_nxt   = r_clr;
    case (r_state)
      POR: begin
        if (r_cnt >= LP_POR_LAST) begin
          w_state_nxt = INIT;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_clr_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      INIT: begin
        if (r_clr) begin
          if (r_cnt >= LP_CLR_LAST) begin
            w_clr_nxt = 1'b0;
            w_cnt_nxt = '0;
            w_idx_nxt = r_idx + 4'd1;
          end else begin
            w_cnt_nxt = r_cnt + 32'd1;
          end
        end else if (w_xfer_end) begin
          w_cnt_nxt = '0;
          if (r_idx == 4'd3) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
          end else if ((r_idx == 4'd2) && (CLR_WAIT > 0)) begin
            // Clear-display needs extra settling time before the next command.
            w_clr_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      IDLE: begin
        if (r_pend || iMSG_VALID) begin
          w_state_nxt = ADDR1;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      ADDR1, ADDR2: begin
        if (w_xfer_end) begin
          w_state_nxt = (r_state == ADDR1) ? LINE1 : LINE2;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      LINE1, LINE2: begin
        if (w_xfer_end) begin
          w_cnt_nxt = '0;
          if (r_idx == 4'd15) begin
            w_state_nxt = (r_state == LINE1) ? ADDR2 : DONE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: w_state_nxt = POR;
    endcase
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= POR;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_clr   <= w_clr_nxt;
    end
  end

  // Request capture: frame latch taken at IDLE exit, one-deep pending while busy.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sel      <= '0;
      r_id       <= '0;
      r_pend     <= 1'b0;
      r_pend_sel <= '0;
      r_pend_id  <= '0;
    end else begin
      if ((r_state == IDLE) && r_pend) begin
        r_sel <= r_pend_sel;
        r_id  <= r_pend_id;
      end else if ((r_state == IDLE) && iMSG_VALID) begin
        r_sel <= iMSG_SEL;
        r_id  <= iID;
      end
      if (iMSG_VALID && w_busy) begin
        r_pend     <= 1'b1;
        r_pend_sel <= iMSG_SEL;
        r_pend_id  <= iID;
      end else if ((r_state == IDLE) && r_pend) begin
        r_pend <= 1'b0;
      end
    end
  end

  // Registered LCD pins; data/RS held between transfers, EN cleared asynchronously.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_lcd_data <= 8'h00;
      r_lcd_rs   <= 1'b0;
      r_lcd_en   <= 1'b0;
    end else begin
      r_lcd_en <= w_en;
      if (w_xfer) begin
        r_lcd_data <= w_byte;
        r_lcd_rs   <= w_rs;
      end
    end
  end

  assign LCD_DATA = r_lcd_data;
  assign LCD_RS   = r_lcd_rs;
  assign LCD_EN   = r_lcd_en;
  assign LCD_RW   = 1'b0;
  assign oBUSY    = w_busy;
  assign oDONE    = (r_state == DONE);

endmodule

// File: tb/tb_lcd_msg_ctrl.sv
// Directed bench for lcd_msg_ctrl: two instances (no blanking / blanking)
// with small timing parameters; bus monitors collect every byte strobed.
module tb_lcd_msg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_vld, b_vld;
  logic [3:0]  a_sel, b_sel;
  logic [27:0] a_id, b_id;
  logic        a_busy, a_done, a_rw, a_en, a_rs;
  logic        b_busy, b_done, b_rw, b_en, b_rs;
  logic [7:0]  a_data, b_data;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic [8:0] xq[$];
  int         ra[$];
  int         a_hi, a_hibad, a_stbad, a_done_n, b_done_n;
  logic       a_en_q, b_en_q;
  logic [8:0] a_cur;

  always #5 clk = ~clk;

  lcd_msg_ctrl #(.CLK_DIV(2), .POR_WAIT(10), .CLR_WAIT(5), .N_DIGITS(7), .BLANK_LZ(0)) u_a (
    .iCLK(clk), .iRST_N(rst_n), .iMSG_VALID(a_vld), .iMSG_SEL(a_sel), .iID(a_id),
    .oBUSY(a_busy), .oDONE(a_done), .LCD_DATA(a_data), .LCD_RW(a_rw), .LCD_EN(a_en), .LCD_RS(a_rs));

  lcd_msg_ctrl #(.CLK_DIV(2), .POR_WAIT(10), .CLR_WAIT(5), .N_DIGITS(7), .BLANK_LZ(1)) u_b (
    .iCLK(clk), .iRST_N(rst_n), .iMSG_VALID(b_vld), .iMSG_SEL(b_sel), .iID(b_id),
    .oBUSY(b_busy), .oDONE(b_done), .LCD_DATA(b_data), .LCD_RW(b_rw), .LCD_EN(b_en), .LCD_RS(b_rs));

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor A: byte log, EN high width and data/RS stability while EN is high.
  always @(negedge clk) begin
    if (a_en && !a_en_q) begin
      qa.push_back({a_rs, a_data});
      ra.push_back(cyc);
      a_cur = {a_rs, a_data};
      a_hi  = 1;
    end else if (a_en) begin
      a_hi++;
      if ({a_rs, a_data} !== a_cur) a_stbad++;
    end else if (a_en_q) begin
      if (a_hi != 2) a_hibad++;
      if ({a_rs, a_data} !== a_cur) a_stbad++;
    end
    if (a_done) a_done_n++;
    a_en_q = a_en;
  end

  // Bus monitor B: byte log only.
  always @(negedge clk) begin
    if (b_en && !b_en_q) qb.push_back({b_rs, b_data});
    if (b_done) b_done_n++;
    b_en_q = b_en;
  end

  // Expected frame model: address commands plus 16 data characters per line.
  task automatic add_frame(input string l1, input string l2);
    xq.push_back(9'h080);
    for (int i = 0; i < 16; i++) xq.push_back({1'b1, l1[i]});
    xq.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) xq.push_back({1'b1, l2[i]});
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (a_data !== 8'h00) $display("FAIL reset_data: got %h want 00", a_data); else passed++;
    total++; if (a_en !== 1'b0) $display("FAIL reset_en: got %b want 0", a_en); else passed++;
    total++; if (a_rs !== 1'b0) $display("FAIL reset_rs: got %b want 0", a_rs); else passed++;
    total++; if (a_rw !== 1'b0) $display("FAIL reset_rw: got %b want 0", a_rw); else passed++;
    total++; if (a_done !== 1'b0) $display("FAIL reset_done: got %b want 0", a_done); else passed++;
    total++; if (a_busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", a_busy); else passed++;
  endtask

  task automatic test_init;
    int n;
    logic [8:0] got;
    logic [8:0] cmds[4];
    cmds = '{9'h038, 9'h00C, 9'h001, 9'h006};
    qa.delete(); ra.delete(); a_hibad = 0; a_stbad = 0; a_done_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (a_busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    total++; if (n >= 200) $display("FAIL init_timeout: busy still %b after %0d cycles", a_busy, n); else passed++;
    total++; if (qa.size() != 4) $display("FAIL init_count: got %0d bytes want 4", qa.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      got = (i < qa.size()) ? qa[i] : 9'h1FF;
      total++; if (got !== cmds[i]) $display("FAIL init_cmd%0d: got %h want %h", i, got, cmds[i]); else passed++;
    end
    if (ra.size() == 4) begin
      total++; if (ra[1] - ra[0] != 6) $display("FAIL init_spacing: got %0d want 6", ra[1] - ra[0]); else passed++;
      total++; if (ra[3] - ra[2] != 11) $display("FAIL init_clr_gap: got %0d want 11", ra[3] - ra[2]); else passed++;
    end
    total++; if (a_hibad != 0) $display("FAIL init_en_width: %0d bad pulses want 0", a_hibad); else passed++;
    total++; if (a_done_n != 0) $display("FAIL init_no_done: got %0d want 0", a_done_n); else passed++;
    repeat (4) @(negedge clk);
    qb.delete(); b_done_n = 0;
  endtask

  task automatic test_granted;
    int n;
    logic [8:0] got;
    qa.delete(); xq.delete(); a_hibad = 0; a_stbad = 0; a_done_n = 0;
    add_frame(" ACCESS GRANTED ", "   ID: 1234567  ");
    @(negedge clk);
    a_sel = 4'd1; a_id = 28'h1234567; a_vld = 1'b1;
    @(negedge clk);
    // Inputs change mid-frame without a strobe; the frame must not follow them.
    a_vld = 1'b0; a_sel = 4'd3; a_id = 28'h7654321;
    n = 0;
    while (a_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    total++; if (n != 204) $display("FAIL granted_latency: got %0d cycles want 204", n); else passed++;
    repeat (4) @(negedge clk);
    total++; if (qa.size() != 34) $display("FAIL granted_count: got %0d bytes want 34", qa.size()); else passed++;
    for (int i = 0; i < 34; i++) begin
      got = (i < qa.size()) ? qa[i] : 9'h1FF;
      total++; if (got !== xq[i]) $display("FAIL granted_byte%0d: got %h want %h", i, got, xq[i]); else passed++;
    end
    total++; if (a_done_n != 1) $display("FAIL granted_done_pulses: got %0d want 1", a_done_n); else passed++;
    total++; if (a_busy !== 1'b0) $display("FAIL granted_busy_after: got %b want 0", a_busy); else passed++;
    total++; if (a_hibad != 0) $display("FAIL granted_en_width: %0d bad pulses want 0", a_hibad); else passed++;
    total++; if (a_stbad != 0) $display("FAIL granted_stability: %0d changes want 0", a_stbad); else passed++;
  endtask

  task automatic test_hex_no_blank;
    int n;
    logic [8:0] got;
    qa.delete(); xq.delete();
    add_frame(" ACCESS GRANTED ", "   ID: 00000A0  ");
    @(negedge clk); a_sel = 4'd1; a_id = 28'h00000A0; a_vld = 1'b1;
    @(negedge clk); a_vld = 1'b0;
    n = 0;
    while (a_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 34; i++) begin
      got = (i < qa.size()) ? qa[i] : 9'h1FF;
      total++; if (got !== xq[i]) $display("FAIL hex_byte%0d: got %h want %h", i, got, xq[i]); else passed++;
    end
  endtask

  task automatic test_blank_lz;
    int n;
    logic [8:0] got;
    logic [27:0] ids[2];
    ids = '{28'h00000A0, 28'h0000000};
    for (int v = 0; v < 2; v++) begin
      qb.delete(); xq.delete();
      if (v == 0) add_frame(" ACCESS GRANTED ", "   ID:      A0  ");
      else        add_frame(" ACCESS GRANTED ", "   ID:       0  ");
      @(negedge clk); b_sel = 4'd1; b_id = ids[v]; b_vld = 1'b1;
      @(negedge clk); b_vld = 1'b0;
      n = 0;
      while (b_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
      total++; if (n >= 400) $display("FAIL blank%0d_timeout: no done after %0d cycles", v, n); else passed++;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 34; i++) begin
        got = (i < qb.size()) ? qb[i] : 9'h1FF;
        total++; if (got !== xq[i]) $display("FAIL blank%0d_byte%0d: got %h want %h", v, i, got, xq[i]); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [8:0] got;
    qa.delete(); xq.delete(); a_done_n = 0;
    add_frame("   Enter Your   ", "   ID to Park   ");
    add_frame("Administrator   ", "Mode            ");
    @(negedge clk); a_sel = 4'd0; a_id = '0; a_vld = 1'b1;
    @(negedge clk); a_vld = 1'b0;
    repeat (20) @(negedge clk);
    a_sel = 4'd2; a_vld = 1'b1;
    @(negedge clk); a_vld = 1'b0;
    repeat (20) @(negedge clk);
    a_sel = 4'd4; a_vld = 1'b1;
    @(negedge clk); a_vld = 1'b0;
    n = 0;
    while (a_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    total++; if (a_busy !== 1'b1) $display("FAIL b2b_busy_pending: got %b want 1", a_busy); else passed++;
    n = 0;
    while (a_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    total++; if (n >= 400) $display("FAIL b2b_second_timeout: no done after %0d cycles", n); else passed++;
    repeat (300) @(negedge clk);
    total++; if (a_done_n != 2) $display("FAIL b2b_done_pulses: got %0d want 2", a_done_n); else passed++;
    total++; if (qa.size() != 68) $display("FAIL b2b_count: got %0d bytes want 68", qa.size()); else passed++;
    for (int i = 0; i < 68; i++) begin
      got = (i < qa.size()) ? qa[i] : 9'h1FF;
      total++; if (got !== xq[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, got, xq[i]); else passed++;
    end
  endtask

  task automatic test_unknown_sel;
    int n;
    logic [8:0] got;
    qa.delete(); xq.delete();
    add_frame("        X       ", "                ");
    @(negedge clk); a_sel = 4'd9; a_vld = 1'b1;
    @(negedge clk); a_vld = 1'b0;
    n = 0;
    while (a_done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 34; i++) begin
      got = (i < qa.size()) ? qa[i] : 9'h1FF;
      total++; if (got !== xq[i]) $display("FAIL sel9_byte%0d: got %h want %h", i, got, xq[i]); else passed++;
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [8:0] got;
    logic [8:0] cmds[4];
    cmds = '{9'h038, 9'h00C, 9'h001, 9'h006};
    qa.delete();
    @(negedge clk); a_sel = 4'd4; a_vld = 1'b1;
    @(negedge clk); a_vld = 1'b0;
    n = 0;
    while (!(qa.size() >= 4 && a_en === 1'b1) && n < 200) begin @(negedge clk); #1; n++; end
    total++; if (n >= 200) $display("FAIL rstmid_reach_line1: EN high not seen in %0d cycles", n); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (a_en !== 1'b0) $display("FAIL rstmid_en_drop: got %b want 0", a_en); else passed++;
    total++; if (a_busy !== 1'b1) $display("FAIL rstmid_busy: got %b want 1", a_busy); else passed++;
    total++; if (a_data !== 8'h00) $display("FAIL rstmid_data: got %h want 00", a_data); else passed++;
    repeat (2) @(negedge clk);
    qa.delete(); a_hibad = 0; a_stbad = 0; a_done_n = 0;
    rst_n = 1'b1;
    n = 0;
    while (a_busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    total++; if (qa.size() != 4) $display("FAIL rstmid_init_count: got %0d bytes want 4", qa.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      got = (i < qa.size()) ? qa[i] : 9'h1FF;
      total++; if (got !== cmds[i]) $display("FAIL rstmid_cmd%0d: got %h want %h", i, got, cmds[i]); else passed++;
    end
    repeat (60) @(negedge clk);
    total++; if (a_done_n != 0) $display("FAIL rstmid_no_done: got %0d want 0", a_done_n); else passed++;
    total++; if (a_busy !== 1'b0) $display("FAIL rstmid_idle: busy got %b want 0", a_busy); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    a_vld = 1'b0; a_sel = '0; a_id = '0;
    b_vld = 1'b0; b_sel = '0; b_id = '0;
    a_hi = 0; a_hibad = 0; a_stbad = 0; a_done_n = 0; b_done_n = 0;
    a_en_q = 1'b0; b_en_q = 1'b0; a_cur = '0;
    test_reset;
    test_init;
    test_granted;
    test_hex_no_blank;
    test_blank_lz;
    test_back_to_back;
    test_unknown_sel;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lcd_msg_ctrl.md
LCD_MSG_CTRL -- requirements
Module: lcd_msg_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50, giving clock cycles per LCD_EN phase.
REQ-002 The block SHALL have parameter POR_WAIT, default 750000, giving the power-up delay in cycles.
REQ-003 The block SHALL have parameter CLR_WAIT, default 100000, giving the extra wait in cycles after a clear command.
REQ-004 The block SHALL have parameter N_DIGITS, default 7, giving the number of BCD/hex ID digits; legal range 1..9.
REQ-005 The block SHALL have parameter BLANK_LZ, default 0, enabling leading-zero blanking when set to 1.
REQ-006 iCLK  input  1  single system clock; all logic on its rising edge.
REQ-007 iRST_N  input  1  reset, asynchronous, active-low.
REQ-008 iMSG_VALID  input  1  one-cycle strobe requesting a display update.
REQ-009 iMSG_SEL  input  4  message selector, sampled with iMSG_VALID.
REQ-010 iID  input  4*N_DIGITS  ID nibbles, most-significant digit in the top nibble, sampled with iMSG_VALID.
REQ-011 oBUSY  output  1  high while initializing or writing a frame.
REQ-012 oDONE  output  1  one-cycle pulse when a frame write completes.
REQ-013 LCD_DATA  output  8  HD44780 data bus.
REQ-014 LCD_RW  output  1  read/write select; tied to 0 (write only).
REQ-015 LCD_EN  output  1  enable strobe.
REQ-016 LCD_RS  output  1  register select: 0 command, 1 data.

Function
REQ-017 The FSM SHALL use states POR, INIT, IDLE, ADDR1, LINE1, ADDR2, LINE2 and DONE.
REQ-018 A byte transfer SHALL drive LCD_DATA and LCD_RS, then hold LCD_EN low for CLK_DIV cycles, high for CLK_DIV cycles, and low for CLK_DIV cycles, for 3*CLK_DIV cycles total; LCD_DATA and LCD_RS SHALL be stable throughout.
REQ-019 POR SHALL wait POR_WAIT cycles, then go to INIT.
REQ-020 INIT SHALL send commands 0x38, 0x0C, 0x01, 0x06 in order, inserting CLR_WAIT idle cycles after 0x01, then go to IDLE.
REQ-021 In IDLE, iMSG_VALID SHALL latch iMSG_SEL and iID and go to ADDR1 on the next cycle.
REQ-022 ADDR1 SHALL send command 0x80; LINE1 SHALL send 16 data bytes; ADDR2 SHALL send 0xC0; LINE2 SHALL send 16 data bytes; DONE SHALL pulse oDONE for 1 cycle and return to IDLE.
REQ-023 Message table (line1 / line2, 16 chars each, space-padded):
- 0 = "   Enter Your   " / "   ID to Park   "
- 1 = " ACCESS GRANTED " / "   ID: " + digits
- 2 = " ACCESS DENIED  " / "   Try Again    "
- 3 = "   Enter Your   " / "   ID to Exit   "
- 4 = "Administrator   " / "Mode            "
- 15 = "    Parking     " / "       OFF      "
- others = "        X       " / 16 spaces
REQ-024 Digit encoding SHALL be: nibble 0..9 -> 0x30+n; nibble 10..15 -> 0x41+(n-10), i.e. 'A'..'F'.
REQ-025 With BLANK_LZ=1, leading zero digits SHALL be sent as 0x20, except the least-significant digit, which SHALL always be shown.
REQ-026 Message 1 digits SHALL occupy columns 7..(6+N_DIGITS), and the remaining columns SHALL be 0x20.
REQ-027 iMSG_VALID while oBUSY is high SHALL store a one-deep pending request, with the latest strobe overwriting any earlier one; the pending request SHALL be served from IDLE on the cycle after DONE.
REQ-028 The latched message and ID SHALL NOT change during a frame.
REQ-029 oBUSY SHALL be low only in IDLE with no pending request.

Reset
REQ-030 While iRST_N=0, outputs SHALL be: LCD_DATA=0x00, LCD_EN=0, LCD_RS=0, LCD_RW=0, oDONE=0, oBUSY=1; the FSM SHALL be in POR and the pending flag cleared.
REQ-031 Reset asserted mid-transfer SHALL drop LCD_EN immediately (asynchronously), and the full POR/INIT sequence SHALL rerun after release.

Verification (CLK_DIV=2, POR_WAIT=10, CLR_WAIT=5)
REQ-032 Release reset -> 4 INIT bytes 38,0C,01,06 with RS=0, each EN high exactly 2 cycles, 5-cycle gap after 01; oBUSY falls at IDLE entry.
REQ-033 Strobe sel=1, iID=0x1234567 -> bytes 80, then 16 bytes of " ACCESS GRANTED ", then C0, then "   ID: 1234567  " with RS=1; oDONE pulses once; frame takes 34*6 cycles.
REQ-034 BLANK_LZ=1, sel=1, iID=0x00000A0 -> line2 "   ID:      A0  "; with iID=0 -> single '0' at column 13.
REQ-035 Two strobes during a frame (sel=2 then sel=4) -> exactly one following frame, showing "Administrator".
REQ-036 sel=9 -> line1 "        X       ", line2 all 0x20.
REQ-037 Reset pulse during LINE1 with EN high -> EN=0 within the same cycle; after release, INIT repeats and no oDONE is seen until a new strobe.
